// File: rtl/apb_mux_wd_pkg.sv
// Shared types and sizing helpers for the APB slave multiplexer with
// decode-error and timeout tracking.
package apb_mux_pkg;

   typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_DECERR} state_t;

   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Timer must hold values up to TIMEOUT; a disabled timeout still gets 1 bit
   function automatic int tmr_width(input int tmo);
      return clog2_min1(tmo + 1);
   endfunction

endpackage

// File: rtl/apb_mux_wd_if.sv
// Master-side APB bus between the bridge and the slave multiplexer.
interface apb_mux_wd_if #(
   parameter int PADDR_SIZE = 8,
   parameter int PDATA_SIZE = 8
);
   logic                  MST_PSEL;
   logic                  MST_PENABLE;
   logic [PADDR_SIZE-1:0] MST_PADDR;
   logic [PDATA_SIZE-1:0] MST_PRDATA;
   logic                  MST_PREADY;
   logic                  MST_PSLVERR;

   modport master (output MST_PSEL, MST_PENABLE, MST_PADDR,
                   input  MST_PRDATA, MST_PREADY, MST_PSLVERR);
   modport slave  (input  MST_PSEL, MST_PENABLE, MST_PADDR,
                   output MST_PRDATA, MST_PREADY, MST_PSLVERR);
endinterface

// File: rtl/apb_mux_wd_decode.sv
// Fixed-priority address decoder: lowest-index matching slave wins.
module apb_mux_decode
   import apb_mux_pkg::*;
#(
   parameter int PADDR_SIZE = 8,
   parameter int SLAVES     = 8,
   parameter int IW         = clog2_min1(SLAVES)
) (
   input  logic [PADDR_SIZE-1:0]             paddr,
   input  logic [SLAVES-1:0][PADDR_SIZE-1:0] slv_addr,
   input  logic [SLAVES-1:0][PADDR_SIZE-1:0] slv_mask,
   output logic [SLAVES-1:0]                 winner,
   output logic                              hit,
   output logic [IW-1:0]                     idx
);

   // Scan high to low so the last match written is the lowest index
   always_comb begin
      winner = '0;
      hit    = 1'b0;
      idx    = '0;
      for (int s = SLAVES - 1; s >= 0; s--) begin
         if ((paddr & slv_mask[s]) == (slv_addr[s] & slv_mask[s])) begin
            winner    = '0;
            winner[s] = 1'b1;
            hit       = 1'b1;
            idx       = IW'(s);
         end
      end
   end

endmodule

// File: rtl/apb_mux_wd.sv
// APB slave multiplexer: latched slave select, decode-error and timeout
// termination, saturating error counters and a registered error pulse.
module apb_mux_wd
   import apb_mux_pkg::*;
#(
   parameter int PADDR_SIZE = 8,
   parameter int PDATA_SIZE = 8,
   parameter int SLAVES     = 8,
   parameter int TIMEOUT    = 16,
   parameter int CNT_SIZE   = 8
) (
   input  logic                              PCLK,
   input  logic                              PRESET,
   apb_mux_wd_if.slave                       mst,
   input  logic [SLAVES-1:0][PADDR_SIZE-1:0] slv_addr,
   input  logic [SLAVES-1:0][PADDR_SIZE-1:0] slv_mask,
   output logic [SLAVES-1:0]                 SLV_PSEL,
   input  logic [SLAVES-1:0][PDATA_SIZE-1:0] SLV_PRDATA,
   input  logic [SLAVES-1:0]                 SLV_PREADY,
   input  logic [SLAVES-1:0]                 SLV_PSLVERR,
   input  logic                              err_clr,
   output logic [CNT_SIZE-1:0]               decerr_cnt,
   output logic [CNT_SIZE-1:0]               tmoerr_cnt,
   output logic                              err_irq
);

   localparam int IW = clog2_min1(SLAVES);
   localparam int TW = tmr_width(TIMEOUT);
   localparam logic [TW-1:0] TMO_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : TW'(0);

   state_t                state_q, state_d;
   logic [IW-1:0]         sel_idx_q, sel_idx_d;
   logic [TW-1:0]         timer_q, timer_d;
   logic [CNT_SIZE-1:0]   decerr_q, decerr_d, tmoerr_q, tmoerr_d;
   logic                  err_irq_q, err_irq_d;
   logic                  dec_inc, tmo_inc;
   logic [SLAVES-1:0]     winner, psel;
   logic                  hit, pready, pslverr;
   logic [IW-1:0]         win_idx;
   logic [PDATA_SIZE-1:0] prdata;

   apb_mux_decode #(.PADDR_SIZE(PADDR_SIZE), .SLAVES(SLAVES), .IW(IW)) u_decode (
      .paddr    (mst.MST_PADDR),
      .slv_addr (slv_addr),
      .slv_mask (slv_mask),
      .winner   (winner),
      .hit      (hit),
      .idx      (win_idx)
   );

   always_comb begin
      state_d   = state_q;
      sel_idx_d = sel_idx_q;
      timer_d   = timer_q;
      dec_inc   = 1'b0;
      tmo_inc   = 1'b0;
      psel      = '0;
      pready    = 1'b0;
      pslverr   = 1'b0;
      prdata    = '0;
      case (state_q)
         ST_IDLE: begin
            timer_d = '0;
            if (mst.MST_PSEL) begin
               psel      = winner;
               sel_idx_d = win_idx;
               // Enable without a setup phase is terminated like an unmapped access
               if (mst.MST_PENABLE) begin
                  pready  = 1'b1;
                  pslverr = 1'b1;
                  dec_inc = 1'b1;
               end else begin
                  state_d = hit ? ST_ACCESS : ST_DECERR;
               end
            end
         end
         ST_ACCESS: begin
            if (!mst.MST_PSEL) begin
               state_d = ST_IDLE;
               timer_d = '0;
            end else begin
               psel[sel_idx_q] = 1'b1;
               if (mst.MST_PENABLE) begin
                  if (SLV_PREADY[sel_idx_q]) begin
                     pready  = 1'b1;
                     pslverr = SLV_PSLVERR[sel_idx_q];
                     prdata  = SLV_PRDATA[sel_idx_q];
                     state_d = ST_IDLE;
                     timer_d = '0;
                  end else if (TIMEOUT > 0 && timer_q == TMO_LAST) begin
                     pready  = 1'b1;
                     pslverr = 1'b1;
                     tmo_inc = 1'b1;
                     state_d = ST_IDLE;
                     timer_d = '0;
                  end else begin
                     pslverr = SLV_PSLVERR[sel_idx_q];
                     prdata  = SLV_PRDATA[sel_idx_q];
                     if (TIMEOUT > 0) timer_d = timer_q + 1'b1;
                  end
               end
            end
         end
         ST_DECERR: begin
            if (!mst.MST_PSEL) begin
               state_d = ST_IDLE;
            end else if (mst.MST_PENABLE) begin
               pready  = 1'b1;
               pslverr = 1'b1;
               dec_inc = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      decerr_d  = err_clr ? '0 : (dec_inc && decerr_q != '1) ? decerr_q + 1'b1 : decerr_q;
      tmoerr_d  = err_clr ? '0 : (tmo_inc && tmoerr_q != '1) ? tmoerr_q + 1'b1 : tmoerr_q;
      err_irq_d = dec_inc | tmo_inc;
   end

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         state_q   <= ST_IDLE;
         sel_idx_q <= '0;
         timer_q   <= '0;
         decerr_q  <= '0;
         tmoerr_q  <= '0;
         err_irq_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         sel_idx_q <= sel_idx_d;
         timer_q   <= timer_d;
         decerr_q  <= decerr_d;
         tmoerr_q  <= tmoerr_d;
         err_irq_q <= err_irq_d;
      end
   end

   // Combinational paths are gated so reset silences the bus immediately
   assign SLV_PSEL        = psel & {SLAVES{~PRESET}};
   assign mst.MST_PREADY  = pready & ~PRESET;
   assign mst.MST_PSLVERR = pslverr & ~PRESET;
   assign mst.MST_PRDATA  = prdata & {PDATA_SIZE{~PRESET}};
   assign decerr_cnt      = decerr_q;
   assign tmoerr_cnt      = tmoerr_q;
   assign err_irq         = err_irq_q;

endmodule
